id_wb_scoreboard: RTL and testbench
===================================

Name: id_wb_scoreboard

Overview:
- Return path from execute/writeback back into decode: holds the register file, takes result writebacks, and tracks in-flight destination registers.
- Decode uses it to read operands (with same-cycle writeback bypass) and to decide whether an instruction may issue into the ID/IE latch.
- A stall is raised on read-after-write or counter-saturation hazards.
- Sits beside the decode stage; the writeback port is driven from the end of the execute pipe.

Parameters:
- NUM_REGS, 16, number of architectural registers (address width fixed at 4 bits).
- DATA_W, 16, register and writeback data width.
- CNT_W, 2, width of each per-register in-flight counter (max outstanding writes per register = 2^CNT_W-1 = 3).

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_writes  in  1  presented instruction writes a destination register
- issue_wb_reg  in  4  destination register of the presented instruction
- rd_use1  in  1  operand 1 is a register read
- rd_addr1  in  4  operand 1 register address
- rd_use2  in  1  operand 2 is a register read
- rd_addr2  in  4  operand 2 register address
- rd_data1  out  DATA_W  operand 1 data (combinational)
- rd_data2  out  DATA_W  operand 2 data (combinational)
- stall  out  1  instruction not accepted; decode holds it (combinational)
- wb_valid  in  1  writeback strobe from execute end
- wb_reg  in  4  writeback destination
- wb_data  in  DATA_W  writeback value
- busy_mask  out  NUM_REGS  registered, bit i set when counter i is nonzero
- wb_error  out  1  registered, sticky writeback-without-issue flag

Behaviour:
- Reset (rst=1 at a clock edge): all registers become 0, all counters become 0, busy_mask=0, wb_error=0. Reset overrides any same-cycle issue or writeback. While rst is high, stall=0 and reads return the bypass or register value as below.
- Reads:
  - rd_dataN = wb_data when wb_valid is high and wb_reg equals rd_addrN; otherwise regs[rd_addrN].
  - When rd_useN=0, rd_dataN is still driven, but the value is don't-care for decode.
- Writeback: on an edge with wb_valid=1, regs[wb_reg] <= wb_data and cnt[wb_reg] is decremented.
  - If cnt[wb_reg] is already 0, the counter stays 0, the data is still written, and wb_error is set. wb_error stays set until reset.
- Hazard per operand: hazN = rd_useN and effective_busy(rd_addrN).
  - effective_busy(r) = cnt[r] > 1, or (cnt[r] == 1 and not (wb_valid and wb_reg == r)).
  - This means a writeback arriving in the same cycle resolves the hazard without a bubble.
- Saturation: sat = issue_writes and cnt[issue_wb_reg] == max, with the same-cycle writeback credit applied. A writeback to that register in the same cycle un-saturates it.
- stall = issue_valid and (haz1 or haz2 or sat).
- Accept = issue_valid and not stall. On accept with issue_writes=1, cnt[issue_wb_reg] is incremented.
- Counter update for the same register in one cycle:
  - Increment and decrement together leave the count unchanged.
  - Increment only: +1.
  - Decrement only: -1.
  - A counter never wraps in either direction.
- Stalled instructions cause no state change. Decode re-presents the same instruction next cycle.
- An instruction whose source equals its own destination checks only the source hazard; the increment happens on accept.
- busy_mask[i] is updated on the edge to reflect the post-update counter i != 0. It has one cycle of latency relative to the counters and is for debug/status only; stall never uses it.
- No state machine beyond the counters. Latency: writeback to architectural read visibility is 0 cycles via bypass, or 1 cycle via the register array.

Test Plan:
- Reset then read: rst for 2 cycles, rd_addr1=5 -> rd_data1=0, busy_mask=0, wb_error=0, stall=0.
- RAW stall then release:
  - Issue writes r3 (accepted, busy_mask[3]=1 next cycle).
  - Next instruction uses rd_addr1=3 -> stall=1 for 2 cycles.
  - wb_valid, wb_reg=3, wb_data=16'hBEEF in the third cycle -> stall=0 the same cycle, rd_data1=16'hBEEF (bypass), accepted.
- Saturation:
  - Issue 3 writes to r7 with no writeback -> cnt=3.
  - 4th issue to r7 -> stall=1.
  - Same cycle wb to r7 -> stall=0, cnt stays 3.
- Simultaneous issue and writeback on r2 with cnt=1: accept and wb in the same edge -> cnt stays 1, busy_mask[2] stays 1, regs[2] updated.
- Spurious writeback: wb_valid to r9 with cnt=0, data 16'h0042 -> regs[9]=16'h0042, cnt 0, wb_error=1 and stays 1 until rst.
- Reset mid-operation: cnt[4]=2 outstanding, rst asserted with a same-cycle issue to r4 -> all counters 0, busy_mask=0, regs 0 after the edge.

Source files
------------

// File: rtl/id_wb_scoreboard.sv
// id_wb_scoreboard: register file, writeback port and in-flight destination
// tracking for the decode stage. Operand reads bypass a same-cycle writeback,
// and issue is stalled on read-after-write or counter-saturation hazards.
module id_wb_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_writes,
    input  logic [3:0]          issue_wb_reg,
    input  logic                rd_use1,
    input  logic [3:0]          rd_addr1,
    input  logic                rd_use2,
    input  logic [3:0]          rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                stall,
    input  logic                wb_valid,
    input  logic [3:0]          wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                wb_error
);

    localparam int              AW      = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [CNT_W-1:0]  cnt      [NUM_REGS];
    logic [CNT_W-1:0]  cnt_next [NUM_REGS];

    logic [NUM_REGS-1:0] wb_hit;    // writeback targets register i this cycle
    logic [NUM_REGS-1:0] busy_now;  // write still outstanding after this cycle's writeback
    logic [NUM_REGS-1:0] full_now;  // counter stays at max even after writeback credit
    logic                haz1;
    logic                haz2;
    logic                sat;
    logic                accept;
    logic                wb_spurious;

    // Per-register hazard view, with the same-cycle writeback credited.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional logic so no path leaves it unassigned (no latch).
        wb_hit   = '0;
        busy_now = '0;
        full_now = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wb_hit[i]   = wb_valid && (wb_reg == AW'(i));
            busy_now[i] = (cnt[i] > CNT_ONE) || ((cnt[i] == CNT_ONE) && !wb_hit[i]);
            full_now[i] = (cnt[i] == CNT_MAX) && !wb_hit[i];
        end
    end

    // Operand reads with writeback bypass, stall decision and accept.
    always_comb begin
        rd_data1    = (wb_valid && (wb_reg == rd_addr1)) ? wb_data : regs[rd_addr1];
        rd_data2    = (wb_valid && (wb_reg == rd_addr2)) ? wb_data : regs[rd_addr2];
        haz1        = rd_use1 && busy_now[rd_addr1];
        haz2        = rd_use2 && busy_now[rd_addr2];
        sat         = issue_writes && full_now[issue_wb_reg];
        stall       = !rst && issue_valid && (haz1 || haz2 || sat);
        accept      = issue_valid && !stall;
        wb_spurious = wb_valid && (cnt[wb_reg] == '0);
    end

    // Next counter values: increment on accepted writing issue, decrement on
    // writeback; both together cancel, and neither direction ever wraps.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            logic inc;
            logic dec;
            inc = accept && issue_writes && (issue_wb_reg == AW'(i));
            dec = wb_hit[i] && (cnt[i] != '0);
            cnt_next[i] = cnt[i];
            case ({inc, dec})
                2'b10:   if (cnt[i] != CNT_MAX) cnt_next[i] = cnt[i] + CNT_ONE;
                2'b01:   cnt_next[i] = cnt[i] - CNT_ONE;
                default: cnt_next[i] = cnt[i];
            endcase
        end
    end

    // State update: register file, counters, busy status and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register array is architecturally defined as zero
            // after reset, so it is cleared here rather than left as plain
            // storage; this forces it into flops instead of a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            busy_mask <= '0;
            wb_error  <= 1'b0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            if (wb_valid) begin
                regs[wb_reg] <= wb_data;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i]       <= cnt_next[i];
                busy_mask[i] <= (cnt_next[i] != '0);
            end
            if (wb_spurious) begin
                wb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_wb_scoreboard.sv
// Self-checking bench for id_wb_scoreboard: directed scenarios followed by
// randomized traffic, all checked against a behavioural model that tracks
// outstanding writes per register as plain integers.
module tb_id_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_writes;
    logic [3:0]  issue_wb_reg;
    logic        rd_use1;
    logic [3:0]  rd_addr1;
    logic        rd_use2;
    logic [3:0]  rd_addr2;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic        stall;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic [15:0] busy_mask;
    logic        wb_error;

    always #5 clk = ~clk;

    id_wb_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_writes (issue_writes),
        .issue_wb_reg (issue_wb_reg),
        .rd_use1      (rd_use1),
        .rd_addr1     (rd_addr1),
        .rd_use2      (rd_use2),
        .rd_addr2     (rd_addr2),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .busy_mask    (busy_mask),
        .wb_error     (wb_error)
    );

    // Reference model: architectural registers, outstanding write count per
    // register, and the sticky spurious-writeback flag.
    logic [15:0] m_regs [16];
    int          m_cnt  [16];
    bit          m_err;

    int checks   = 0;
    int failures = 0;

    // Values seen in the most recent cycle, for directed checks.
    logic        last_stall;
    logic [15:0] last_rd1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Writes still outstanding on r once this cycle's writeback (if any) lands.
    function automatic int pending(input int r, input bit wv, input int wr);
        int p;
        p = m_cnt[r];
        if (wv && wr == r && p > 0) p--;
        return p;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, clock the
    // DUT, advance the model, check registered outputs.
    task automatic cycle(input bit r, input bit iv, input bit iw, input int id,
                         input bit u1, input int a1, input bit u2, input int a2,
                         input bit wv, input int wr, input logic [15:0] wd);
        logic [15:0] e_rd1, e_rd2, e_busy;
        bit          e_stall, accepted;
        @(negedge clk);
        rst = r; issue_valid = iv; issue_writes = iw; issue_wb_reg = 4'(id);
        rd_use1 = u1; rd_addr1 = 4'(a1); rd_use2 = u2; rd_addr2 = 4'(a2);
        wb_valid = wv; wb_reg = 4'(wr); wb_data = wd;
        #1;
        e_rd1 = (wv && wr == a1) ? wd : m_regs[a1];
        e_rd2 = (wv && wr == a2) ? wd : m_regs[a2];
        e_stall = !r && iv && ((u1 && pending(a1, wv, wr) > 0) ||
                               (u2 && pending(a2, wv, wr) > 0) ||
                               (iw && pending(id, wv, wr) == 3));
        check("rd_data1", 32'(rd_data1), 32'(e_rd1));
        check("rd_data2", 32'(rd_data2), 32'(e_rd2));
        check("stall", 32'(stall), 32'(e_stall));
        last_stall = stall;
        last_rd1   = rd_data1;
        accepted   = iv && !e_stall;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = '0;
                m_cnt[i]  = 0;
            end
            m_err = 1'b0;
        end else begin
            if (wv) begin
                m_regs[wr] = wd;
                if (m_cnt[wr] > 0) m_cnt[wr]--;
                else m_err = 1'b1;
            end
            if (accepted && iw) m_cnt[id]++;
        end
        e_busy = '0;
        for (int i = 0; i < 16; i++) e_busy[i] = (m_cnt[i] != 0);
        #1;
        check("busy_mask", 32'(busy_mask), 32'(e_busy));
        check("wb_error", 32'(wb_error), 32'(m_err));
    endtask

    task automatic idle_read(input int a);
        cycle(0, 0, 0, 0, 1, a, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
        rst = 1'b1; issue_valid = 0; issue_writes = 0; issue_wb_reg = 0;
        rd_use1 = 0; rd_addr1 = 0; rd_use2 = 0; rd_addr2 = 0;
        wb_valid = 0; wb_reg = 0; wb_data = 0;

        // Reset: first edge initialises the DUT, second is checked with an
        // issue presented to show stall stays low under reset.
        @(posedge clk);
        cycle(1, 1, 1, 5, 1, 5, 1, 5, 0, 0, 16'h0);
        check("reset_stall", 32'(last_stall), 32'd0);
        idle_read(5);
        check("reset_rd5", 32'(last_rd1), 32'd0);
        check("reset_busy", 32'(busy_mask), 32'd0);
        check("reset_err", 32'(wb_error), 32'd0);

        // RAW stall then release through same-cycle writeback bypass.
        cycle(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 16'h0);
        check("raw_issue_busy3", 32'(busy_mask[3]), 32'd1);
        cycle(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 16'h0);
        check("raw_stall_a", 32'(last_stall), 32'd1);
        cycle(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 16'h0);
        check("raw_stall_b", 32'(last_stall), 32'd1);
        cycle(0, 1, 0, 0, 1, 3, 0, 0, 1, 3, 16'hBEEF);
        check("raw_release", 32'(last_stall), 32'd0);
        check("raw_bypass", 32'(last_rd1), 32'hBEEF);
        idle_read(3);
        check("raw_regfile", 32'(last_rd1), 32'hBEEF);

        // Saturation on r7.
        for (int k = 0; k < 3; k++) cycle(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 16'h0);
        cycle(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 16'h0);
        check("sat_stall", 32'(last_stall), 32'd1);
        cycle(0, 1, 1, 7, 0, 0, 0, 0, 1, 7, 16'h7777);
        check("sat_wb_release", 32'(last_stall), 32'd0);
        check("sat_cnt7", 32'(m_cnt[7]), 32'd3);
        cycle(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 16'h0);
        check("sat_still_full", 32'(last_stall), 32'd1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 16'h0700 + 16'(k));
        check("sat_drained", 32'(busy_mask[7]), 32'd0);

        // Simultaneous issue and writeback on r2 with one outstanding write.
        cycle(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 16'h0);
        cycle(0, 1, 1, 2, 0, 0, 0, 0, 1, 2, 16'h5555);
        check("simul_busy2", 32'(busy_mask[2]), 32'd1);
        idle_read(2);
        check("simul_reg2", 32'(last_rd1), 32'h5555);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 16'h5556);

        // Spurious writeback to idle r9 sets the sticky error.
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 16'h0042);
        check("spur_err", 32'(wb_error), 32'd1);
        idle_read(9);
        check("spur_reg9", 32'(last_rd1), 32'h0042);
        for (int k = 0; k < 3; k++) idle_read(k);
        check("spur_sticky", 32'(wb_error), 32'd1);

        // Reset mid-operation with two writes outstanding on r4.
        cycle(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 16'h0);
        cycle(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 16'h0);
        cycle(1, 1, 1, 4, 0, 0, 0, 0, 1, 4, 16'h4444);
        check("rstmid_busy", 32'(busy_mask), 32'd0);
        check("rstmid_err", 32'(wb_error), 32'd0);
        for (int a = 0; a < 16; a++) begin
            idle_read(a);
            check("rstmid_reg", 32'(last_rd1), 32'd0);
        end
        cycle(0, 1, 0, 0, 1, 4, 0, 0, 0, 0, 16'h0);
        check("rstmid_no_haz", 32'(last_stall), 32'd0);

        // Randomized traffic focused on a few registers to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            bit r, iv, iw, u1, u2, wv;
            int id, a1, a2, wr;
            r  = ($urandom_range(0, 49) == 0);
            iv = $urandom_range(0, 3) != 0;
            iw = $urandom_range(0, 1) != 0;
            id = $urandom_range(0, 3);
            u1 = $urandom_range(0, 1) != 0;
            a1 = $urandom_range(0, 4);
            u2 = $urandom_range(0, 1) != 0;
            a2 = $urandom_range(0, 4);
            wv = $urandom_range(0, 1) != 0;
            wr = $urandom_range(0, 3);
            cycle(r, iv, iw, id, u1, a1, u2, a2, wv, wr, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
